// File: rtl/ifu_fetch_fsm.sv
// Purpose : instruction fetch stage; owns the PC, issues one memory read per instruction, hands the word to decode.
// Latency : inst_valid 2 cycles after entering REQ with zero-wait memory; 3 cycles per instruction when inst_ready is tied high.
// Backpress: one outstanding read at a time. HOLD keeps inst/pc/inst_err stable until inst_ready. Build option IFU_PERF_CNT_EN adds the perf counters.
module ifu_fetch_fsm #(
    parameter logic [31:0] RESET_PC       = 32'h8000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_arvalid,
    output logic [31:0] mem_araddr,
    input  logic        mem_arready,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    input  logic [1:0]  mem_rresp,
    output logic        mem_rready,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] pc,
    output logic        inst_err,
    input  logic        jump_en,
    input  logic [31:0] jump_addr,
    output logic        timeout,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_stall_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT_CYCLES);
    localparam bit          TMO_EN    = (TIMEOUT_CYCLES != 0);

    state_t      state_q;
    state_t      state_d;
    logic [15:0] tmo_cnt_q;
    logic [15:0] tmo_cnt_inc;
    logic        in_mem;
    logic        rsp_take;
    logic        inst_take;

    // Handshake qualifiers shared by the state register and the datapath.
    assign in_mem      = (state_q == S_REQ) || (state_q == S_WAIT);
    assign rsp_take    = (state_q == S_WAIT) && mem_rvalid;
    assign inst_take   = (state_q == S_HOLD) && inst_ready;
    assign tmo_cnt_inc = (tmo_cnt_q == 16'hFFFF) ? tmo_cnt_q : tmo_cnt_q + 16'd1;
    assign mem_araddr  = pc;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_d     = state_q;
        mem_arvalid = 1'b0;
        mem_rready  = 1'b0;
        inst_valid  = 1'b0;
        case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
            end
            S_REQ: begin
                mem_arvalid = 1'b1;
                if (mem_arready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                mem_rready = 1'b1;
                if (mem_rvalid) begin
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                inst_valid = 1'b1;
                if (inst_ready) begin
                    state_d = S_REQ;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Instruction register captures the response; PC advances or redirects on consume.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc       <= RESET_PC;
            inst     <= 32'h0;
            inst_err <= 1'b0;
        end else begin
            if (rsp_take) begin
                inst     <= mem_rdata;
                inst_err <= (mem_rresp != 2'b00);
            end
            if (inst_take) begin
                pc <= jump_en ? jump_addr : pc + 32'd4;
            end
        end
    end

    // Hang detector: counts consecutive REQ/WAIT cycles; the flag is sticky until reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            tmo_cnt_q <= 16'h0;
            timeout   <= 1'b0;
        end else begin
            if (rsp_take) begin
                tmo_cnt_q <= 16'h0;
            end else if (in_mem) begin
                tmo_cnt_q <= tmo_cnt_inc;
            end
            if (TMO_EN && in_mem && (tmo_cnt_inc == TMO_LIMIT)) begin
                timeout <= 1'b1;
            end
        end
    end

`ifdef IFU_PERF_CNT_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] stall_cnt_q;

    // Completed fetches and cycles spent waiting on memory; both wrap.
    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_cnt_q <= 32'h0;
            stall_cnt_q <= 32'h0;
        end else begin
            if (inst_take) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end
            if (((state_q == S_REQ) && !mem_arready) || ((state_q == S_WAIT) && !mem_rvalid)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign perf_fetch_cnt = fetch_cnt_q;
    assign perf_stall_cnt = stall_cnt_q;
`else
    assign perf_fetch_cnt = 32'h0;
    assign perf_stall_cnt = 32'h0;
`endif

endmodule
